approx_mul_pipe: RTL
====================

// Module: approx_mul_pipe
// PURPOSE
//  Parametrised, pipelined unsigned approximate multiplier for delay/MSE design-space runs.
//  Carry-save array reduction + ripple final adder; every adder cell in product column c < APPROX_COLS
//  uses a configurable 3-input truth table, columns >= APPROX_COLS use exact full adders.
//  Two-stage valid/ready pipeline; sits between operand source and accuracy/MSE analysis logic.
// PARAMETERS
//  A_W          8      width of operand a
//  B_W          8      width of operand b (>=3)
//  APPROX_COLS  10     product columns [0..APPROX_COLS-1] use approx cells; 0 = exact multiplier
//  FA_SUM_TT    8'hDE  approx sum truth table, bit index {x,y,z} (default = cell 21_123)
//  FA_COUT_TT   8'hA8  approx carry truth table, bit index {x,y,z}
//  ERR_W        40     error-accumulator width (monitor only)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        operands valid
//  in_ready     out  1        stage 1 can accept
//  in_a         in   A_W      operand a
//  in_b         in   B_W      operand b
//  out_valid    out  1        product valid
//  out_ready    in   1        consumer accepts
//  out_p        out  A_W+B_W  approximate product
//  err_clr      in   1        clear error statistics (monitor only)
//  err_cnt      out  32       products retired since clear (monitor only)
//  err_abs_sum  out  ERR_W    sum |exact-approx| (monitor only)
//  err_sq_sum   out  ERR_W    sum (exact-approx)^2, saturating (monitor only)
// BEHAVIOUR
//  - One clock clk; reset rst_n asynchronous, active-low. Reset: out_valid=0, out_p=0, s1 valid=0, all err_*=0.
//  - P_W=A_W+B_W. pp row j = (a & {A_W{b[j]}}) << j, zero-padded to P_W.
//  - Reduction: row 0 cells add pp0,pp1,pp2; row k>0 adds sum_{k-1}, carry_{k-1}<<1, pp_{k+2}; every
//    column 0..P_W-1 of every row has a cell (constant-0 inputs still pass through the cell).
//  - Stage 1 register: final sum/carry vectors. Stage 2: ripple adder (same column rule, cin=0) -> out_p reg.
//  - Latency: 2 cycles in_valid&in_ready -> out_valid, no stalls. Throughput 1/cycle.
//  - Handshake: adv2 = ~out_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1 (combinational,
//    no in_valid dependence). Data held stable while out_valid & ~out_ready. Transfer only on valid&ready.
//  - Simultaneous accept and retire in a cycle is lossless; full pipe with out_ready=0 -> in_ready=0.
//  - Reset mid-operation drops in-flight products; no out_valid until a new accept.
//  - APPROX_COLS >= P_W: all cells approx; product overflow carry (column P_W) is discarded.
// CONFIGURATION
//  - APPROX_MUL_ERRMON_EN defined: exact a*b travels with stage 1/2; on each out_valid&out_ready,
//    err_cnt+=1, err_abs_sum+=|e|, err_sq_sum+=e^2 saturating at all-ones; err_cnt wraps.
//    err_clr zeroes all three; err_clr coincident with retire -> cleared, sample dropped.
//  - Undefined: err_* ports, exact path and accumulators absent; product datapath unchanged.
// STRUCTURE
//  - Package approx_mul_pkg: tt_eval(tt,x,y,z) function, P_W localparam helper, product typedef.
//  - Sub-module approx_fa_cell (X,Y,Z,S,Cout; params IS_APPROX, SUM_TT, COUT_TT), generated per cell.
//  - Top: generate loops for array and final adder, pipeline control, optional monitor.
// TESTING
//  - APPROX_COLS=0, a=255,b=255 -> out_p=65025 after 2 cycles; 10k random pairs match a*b exactly.
//  - APPROX_COLS=16, FA_SUM_TT=8'h96, FA_COUT_TT=8'h00: a=3,b=3 -> out_p=5 (column parity).
//  - Defaults: 10k random pairs match bit-accurate model of same array; columns >=10 carry-exact.
//  - out_ready=0 with 3 accepts: in_ready drops after 2nd, out_p frozen; release -> 3 in order, none lost.
//  - rst_n low during stream -> out_valid=0 immediately (async), out_p=0; restart a=2,b=7 -> 14 (exact cfg).
//  - ERRMON, cfg 8'h96/8'h00, a=3,b=3 twice -> err_cnt=2, err_abs_sum=8, err_sq_sum=32; err_clr -> all 0.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// Shared helpers and types for the pipelined approximate multiplier.
package approx_mul_pkg;

    localparam logic [7:0] EXACT_SUM_TT  = 8'h96;
    localparam logic [7:0] EXACT_COUT_TT = 8'hE8;

    localparam int unsigned DEF_A_W = 8;
    localparam int unsigned DEF_B_W = 8;

    function automatic int unsigned prod_w(input int unsigned a_w, input int unsigned b_w);
        return a_w + b_w;
    endfunction

    localparam int unsigned DEF_P_W = prod_w(DEF_A_W, DEF_B_W);

    typedef logic [DEF_P_W-1:0] product_t;

    // Look up a 3-input truth table; bit index is {x,y,z}.
    function automatic logic tt_eval(input logic [7:0] tt, input logic x, input logic y,
                                     input logic z);
        return tt[{x, y, z}];
    endfunction

endpackage

// File: rtl/approx_fa_cell.sv
// One adder cell: exact full adder, or a truth-table defined approximate cell.
module approx_fa_cell
    import approx_mul_pkg::*;
#(
    parameter bit         IS_APPROX = 1'b0,
    parameter logic [7:0] SUM_TT    = 8'hDE,
    parameter logic [7:0] COUT_TT   = 8'hA8
) (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic cout
);

    localparam logic [7:0] S_TT = IS_APPROX ? SUM_TT : EXACT_SUM_TT;
    localparam logic [7:0] C_TT = IS_APPROX ? COUT_TT : EXACT_COUT_TT;

    assign s    = tt_eval(S_TT, x, y, z);
    assign cout = tt_eval(C_TT, x, y, z);

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage valid/ready approximate multiplier: carry-save array, then ripple adder.
// Optional error monitor enabled by defining APPROX_MUL_ERRMON_EN.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned A_W         = 8,
    parameter int unsigned B_W         = 8,
    parameter int unsigned APPROX_COLS = 10,
    parameter logic [7:0]  FA_SUM_TT   = 8'hDE,
    parameter logic [7:0]  FA_COUT_TT  = 8'hA8,
    parameter int unsigned ERR_W       = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] out_p
`ifdef APPROX_MUL_ERRMON_EN
    ,
    input  logic               err_clr,
    output logic [31:0]        err_cnt,
    output logic [ERR_W-1:0]   err_abs_sum,
    output logic [ERR_W-1:0]   err_sq_sum
`endif
);

    localparam int unsigned P_W = prod_w(A_W, B_W);
    localparam int unsigned NR  = B_W - 2;

    if (B_W < 3 || ERR_W == 0) begin : g_param_check
        $error("approx_mul_pipe: B_W must be >= 3 and ERR_W must be nonzero");
    end

    logic adv1;
    logic adv2;
    logic s1_valid;
    logic [P_W-1:0] s1_sum;
    logic [P_W-1:0] s1_carry;
    logic [P_W-1:0] fin_s;
    logic [P_W-1:0] pp [B_W];

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    for (genvar j = 0; j < B_W; j++) begin : g_pp
        assign pp[j] = (P_W'(in_a) & {P_W{in_b[j]}}) << j;
    end

    // Carry-save rows; the carry out of the top column is the discarded overflow.
    for (genvar k = 0; k < NR; k++) begin : g_row
        logic [P_W-1:0] xv;
        logic [P_W-1:0] yv;
        logic [P_W-1:0] zv;
        logic [P_W-1:0] sv;
        logic [P_W-1:0] cv;
        logic [P_W-1:0] co;
        logic           unused_ovf;

        if (k == 0) begin : g_first
            assign xv = pp[0];
            assign yv = pp[1];
        end else begin : g_next
            assign xv = g_row[k-1].sv;
            assign yv = g_row[k-1].cv;
        end

        assign zv         = pp[k+2];
        assign cv         = {co[P_W-2:0], 1'b0};
        assign unused_ovf = co[P_W-1];

        for (genvar c = 0; c < P_W; c++) begin : g_col
            approx_fa_cell #(
                .IS_APPROX (c < APPROX_COLS),
                .SUM_TT    (FA_SUM_TT),
                .COUT_TT   (FA_COUT_TT)
            ) u_cell (
                .x    (xv[c]),
                .y    (yv[c]),
                .z    (zv[c]),
                .s    (sv[c]),
                .cout (co[c])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_stage1
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_carry <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= g_row[NR-1].sv;
                s1_carry <= g_row[NR-1].cv;
            end
        end
    end

    // Ripple final adder with the same per-column cell choice, cin = 0.
    for (genvar c = 0; c < P_W; c++) begin : g_fin
        logic ci;
        logic co;

        if (c == 0) begin : g_c0
            assign ci = 1'b0;
        end else begin : g_cn
            assign ci = g_fin[c-1].co;
        end

        approx_fa_cell #(
            .IS_APPROX (c < APPROX_COLS),
            .SUM_TT    (FA_SUM_TT),
            .COUT_TT   (FA_COUT_TT)
        ) u_cell (
            .x    (s1_sum[c]),
            .y    (s1_carry[c]),
            .z    (ci),
            .s    (fin_s[c]),
            .cout (co)
        );
    end

    logic unused_fin_ovf;
    assign unused_fin_ovf = g_fin[P_W-1].co;

    always_ff @(posedge clk or negedge rst_n) begin : p_stage2
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_p <= fin_s;
            end
        end
    end

`ifdef APPROX_MUL_ERRMON_EN
    localparam int unsigned SQ_W  = 2 * P_W;
    localparam int unsigned ACC_W = ((ERR_W > SQ_W) ? ERR_W : SQ_W) + 1;

    logic [P_W-1:0]   s1_exact;
    logic [P_W-1:0]   s2_exact;
    logic [P_W-1:0]   e_abs;
    logic [SQ_W-1:0]  e_sq;
    logic [ACC_W-1:0] sq_next;

    // Exact product shadows the approximate one through both stages.
    always_ff @(posedge clk or negedge rst_n) begin : p_exact
        if (!rst_n) begin
            s1_exact <= '0;
            s2_exact <= '0;
        end else begin
            if (adv1 && in_valid) begin
                s1_exact <= P_W'(in_a) * P_W'(in_b);
            end
            if (adv2 && s1_valid) begin
                s2_exact <= s1_exact;
            end
        end
    end

    always_comb begin : p_err_calc
        e_abs   = '0;
        e_sq    = '0;
        sq_next = '0;
        e_abs   = (s2_exact >= out_p) ? (s2_exact - out_p) : (out_p - s2_exact);
        e_sq    = SQ_W'(e_abs) * SQ_W'(e_abs);
        sq_next = ACC_W'(err_sq_sum) + ACC_W'(e_sq);
    end

    // Clear wins over a coincident retire, dropping that sample.
    always_ff @(posedge clk or negedge rst_n) begin : p_err_acc
        if (!rst_n) begin
            err_cnt     <= '0;
            err_abs_sum <= '0;
            err_sq_sum  <= '0;
        end else if (err_clr) begin
            err_cnt     <= '0;
            err_abs_sum <= '0;
            err_sq_sum  <= '0;
        end else if (out_valid && out_ready) begin
            err_cnt     <= err_cnt + 32'd1;
            err_abs_sum <= err_abs_sum + ERR_W'(e_abs);
            err_sq_sum  <= (sq_next > ACC_W'({ERR_W{1'b1}})) ? {ERR_W{1'b1}}
                                                              : ERR_W'(sq_next);
        end
    end
`endif

endmodule
